// File: rtl/botoes_debouncer.sv
// Eight-button debouncer with a single-pulse press reporter.
// Each raw input is synchronized, filtered by its own stability counter,
// and every accepted press is queued in a pending bit.  Pending presses
// drain one per cycle, lowest index first, as one-cycle pulses on botoes.

// Per-button synchronizer, stability counter and rising-edge detect.
module botoes_debouncer_lane #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_stable,
  output logic o_rise
);

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;

  // Sampled value disagrees with the accepted level.
  assign w_diff = r_sync2 ^ r_stable;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreeing samples; accept the new level once the
  // count has been held long enough, any agreeing sample restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_stable <= 1'b0;
    end else if (!w_diff) begin
      r_cnt    <= '0;
    end else if (r_cnt == LP_CNT_MAX) begin
      r_cnt    <= '0;
      r_stable <= r_sync2;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Delayed copy of the accepted level so a 0->1 change shows for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_stable_d <= 1'b0;
    else     r_stable_d <= r_stable;
  end

  assign o_stable = r_stable;
  assign o_rise   = r_stable & ~r_stable_d;

endmodule

// Top level: eight debounce lanes plus the pending-press arbiter.
module botoes_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] botoes_raw,
  input  logic       enable,
  output logic [7:0] botoes,
  output logic [7:0] estavel,
  output logic [7:0] db_pendente
);

  localparam int NUM_LANES = 8;
  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CNT_W     = (DEBOUNCE_CYCLES <= 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic [NUM_LANES-1:0] w_stable;
  logic [NUM_LANES-1:0] w_rise;
  logic [NUM_LANES-1:0] w_grant;
  logic [NUM_LANES-1:0] w_pend_nxt;
  logic [NUM_LANES-1:0] r_pend;
  logic [NUM_LANES-1:0] r_botoes;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      botoes_debouncer_lane #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .i_raw    (botoes_raw[gi]),
        .o_stable (w_stable[gi]),
        .o_rise   (w_rise[gi])
      );
    end
  endgenerate

  // Isolate the lowest set pending bit: x & -x.
  assign w_grant = r_pend & (~r_pend + 8'd1);

  // Next pending: drop the granted bit, new presses win over the clear,
  // and nothing is retained (or captured) while pulses are disabled.
  always_comb begin
    w_pend_nxt = '0;
    if (enable) w_pend_nxt = (r_pend & ~w_grant) | w_rise;
  end

  // Pending register and the registered one-hot press pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend   <= '0;
      r_botoes <= '0;
    end else begin
      r_pend   <= w_pend_nxt;
      r_botoes <= enable ? w_grant : '0;
    end
  end

  assign botoes      = r_botoes;
  assign estavel     = w_stable;
  assign db_pendente = r_pend;

endmodule
